// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
//
// Multiplies use a radix-2 shift-add loop, divides a radix-2 restoring
// shift-subtract loop; both run exactly WIDTH iterations, followed by one
// sign-correction/write-back cycle. MTHI/MTLO complete in a single cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     request strobe, accepted only while idle
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//             100 MADD, 101 MADDU, 110 MTHI, 111 MTLO
//   din1      rs operand (multiplicand / dividend / move source)
//   din2      rt operand (multiplier / divisor)
//   busy      operation in progress
//   done      one-cycle pulse when HI/LO were updated
//   div_zero  pulses with done when a divide had din2 == 0
//   hi, lo    architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opa;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;       // {partial product, multiplier} or {remainder, quotient}
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder must be negated (dividend sign)
    logic               dz_q;

    // Request decode
    logic             is_mt_in;
    logic             is_div_in;
    logic             signed_in;
    logic             sgn1;
    logic             sgn2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             din2_zero;

    always_comb begin
        is_mt_in  = (op[2:1] == 2'b11);
        is_div_in = (op[2:1] == 2'b01);
        signed_in = ~op[0];
        sgn1      = signed_in & din1[WIDTH-1];
        sgn2      = signed_in & din2[WIDTH-1];
        mag1      = sgn1 ? -din1 : din1;
        mag2      = sgn2 ? -din2 : din2;
        din2_zero = (din2 == '0);
    end

    // One radix-2 iteration
    logic               is_div_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] step_nxt;

    always_comb begin
        is_div_q  = (op_q[2:1] == 2'b01);
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
        // Borrow out (bit WIDTH) means the shifted remainder is below the divisor.
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opa};
        if (is_div_q) begin
            if (div_trial[WIDTH]) begin
                step_nxt = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                step_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction and HI/LO write-back value
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod_s = neg_res ? -acc : acc;
        quo_s  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = hi;
        res_lo = lo;
        case (op_q)
            3'b000, 3'b001: begin
                {res_hi, res_lo} = prod_s;
            end
            3'b100, 3'b101: begin
                {res_hi, res_lo} = {hi, lo} + prod_s;
            end
            3'b010, 3'b011: begin
                if (dz_q) begin
                    // opa holds the raw dividend for a zero divisor
                    res_hi = opa;
                    res_lo = '1;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !is_mt_in) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            op_q     <= '0;
            opa      <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            busy     <= (state_nxt != IDLE);
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mt_in) begin
                            if (op[0]) begin
                                lo <= din1;
                            end else begin
                                hi <= din1;
                            end
                            done <= 1'b1;
                        end else begin
                            op_q    <= op;
                            cnt     <= CNT_W'(WIDTH);
                            neg_res <= sgn1 ^ sgn2;
                            neg_rem <= sgn1;
                            dz_q    <= is_div_in & din2_zero;
                            if (is_div_in) begin
                                // A zero divisor never matters to the loop, so
                                // its slot keeps the raw dividend for write-back.
                                opa <= din2_zero ? din1 : mag2;
                                acc <= {{WIDTH{1'b0}}, mag1};
                            end else begin
                                opa <= mag1;
                                acc <= {{WIDTH{1'b0}}, mag2};
                            end
                        end
                    end
                end
                CALC: begin
                    acc <= step_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    hi       <= res_hi;
                    lo       <= res_lo;
                    done     <= 1'b1;
                    div_zero <= dz_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start32;
    logic [2:0]  op32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .din1(a32), .din2(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .din1(a8), .din2(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    int checks = 0;
    int failures = 0;

    // Reference HI/LO state per instance: index 0 = 32-bit, 1 = 8-bit
    logic [31:0] mhi [2];
    logic [31:0] mlo [2];

    typedef struct {
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          stray;
        logic        changed;
        logic        after;
    } res_t;

    function automatic logic cur_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction
    function automatic logic cur_dz(input bit w8);
        return w8 ? dz8 : dz32;
    endfunction
    function automatic logic [31:0] cur_hi(input bit w8);
        return w8 ? {24'b0, hi8} : hi32;
    endfunction
    function automatic logic [31:0] cur_lo(input bit w8);
        return w8 ? {24'b0, lo8} : lo32;
    endfunction

    task automatic drive(input bit w8, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; op32 = op; a32 = a; b32 = b;
        end
    endtask

    // Issues one request and follows it to its done cycle (bounded).
    // lat counts cycles from the accept edge: 1 = done right after that edge.
    task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output res_t r);
        logic [31:0] h0, l0;
        h0 = cur_hi(w8);
        l0 = cur_lo(w8);
        drive(w8, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, 3'($urandom), $urandom, $urandom);
        r.lat = 1; r.stray = 0; r.changed = 1'b0;
        while (!cur_done(w8) && r.lat < 100) begin
            if (cur_dz(w8)) r.stray++;
            if (cur_hi(w8) !== h0 || cur_lo(w8) !== l0) r.changed = 1'b1;
            @(posedge clk); #1;
            r.lat++;
        end
        r.hi = cur_hi(w8);
        r.lo = cur_lo(w8);
        r.dz = cur_dz(w8);
        @(posedge clk); #1;
        r.after = cur_done(w8) | cur_dz(w8);
    endtask

    // Behavioural reference computed with plain integer arithmetic.
    function automatic void model(input int w, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] hi_i,
                                  input logic [31:0] lo_i, output logic [31:0] hi_o,
                                  output logic [31:0] lo_o, output logic dz);
        logic [31:0] wm;
        logic [63:0] pm, p, cur;
        longint      sa, sb, ua, ub, q, rm;
        wm = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        pm = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        ua = longint'({32'b0, a & wm});
        ub = longint'({32'b0, b & wm});
        sa = a[w-1] ? ua - (longint'(1) << w) : ua;
        sb = b[w-1] ? ub - (longint'(1) << w) : ub;
        cur = ({32'b0, hi_i} << w) | {32'b0, lo_i};
        hi_o = hi_i; lo_o = lo_i; dz = 1'b0; p = '0;
        case (op)
            3'd0: p = 64'(sa * sb);
            3'd1: p = 64'(ua * ub);
            3'd4: p = cur + 64'(sa * sb);
            3'd5: p = cur + 64'(ua * ub);
            default: p = '0;
        endcase
        p = p & pm;
        case (op)
            3'd0, 3'd1, 3'd4, 3'd5: begin
                hi_o = 32'(p >> w) & wm;
                lo_o = 32'(p) & wm;
            end
            3'd2, 3'd3: begin
                if (ub == 0) begin
                    lo_o = wm; hi_o = a & wm; dz = 1'b1;
                end else begin
                    if (op == 3'd2) begin
                        q = sa / sb; rm = sa % sb;
                    end else begin
                        q = ua / ub; rm = ua % ub;
                    end
                    lo_o = 32'(q) & wm;
                    hi_o = 32'(rm) & wm;
                end
            end
            3'd6: hi_o = a & wm;
            default: lo_o = a & wm;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand(input int w);
        logic [31:0] wm;
        wm = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1 << (w - 1);
            2: return wm;
            3: return 32'd1;
            default: return $urandom & wm;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd3);
        drive(1'b1, 1'b1, 3'b111, 32'hFF, 32'd3);
        @(posedge clk); @(posedge clk); #1;
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy32: got %b expected 0", busy32); end
        checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL reset_done32: got %b expected 0", done32); end
        checks++; if (hi32 !== 32'd0 || lo32 !== 32'd0) begin failures++; $display("FAIL reset_hilo32: got %h/%h expected 0/0", hi32, lo32); end
        checks++; if (busy8 !== 1'b0 || hi8 !== 8'd0 || lo8 !== 8'd0 || dz8 !== 1'b0) begin
            failures++; $display("FAIL reset_w8: got busy=%b hi=%h lo=%h dz=%b expected 0", busy8, hi8, lo8, dz8);
        end
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    endtask

    task automatic test_directed();
        res_t r;
        run_op(1'b0, 3'b000, 32'hFFFF_FFFD, 32'd5, r);
        checks++; if (r.lat !== 34) begin failures++; $display("FAIL mult_latency: got %0d expected 34", r.lat); end
        checks++; if (r.hi !== 32'hFFFF_FFFF || r.lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_result: got %h_%h expected ffffffff_fffffff1", r.hi, r.lo); end
        checks++; if (r.changed !== 1'b0) begin failures++; $display("FAIL mult_hilo_stable: got changed=%b expected 0", r.changed); end
        run_op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'd2, r);
        checks++; if (r.hi !== 32'h1 || r.lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_result: got %h_%h expected 00000001_fffffffe", r.hi, r.lo); end
        run_op(1'b0, 3'b101, 32'hFFFF_FFFF, 32'd2, r);
        checks++; if (r.hi !== 32'h3 || r.lo !== 32'hFFFF_FFFC) begin failures++; $display("FAIL maddu_result: got %h_%h expected 00000003_fffffffc", r.hi, r.lo); end
        run_op(1'b0, 3'b010, 32'hFFFF_FFF9, 32'd2, r);
        checks++; if (r.hi !== 32'hFFFF_FFFF || r.lo !== 32'hFFFF_FFFD || r.dz !== 1'b0) begin
            failures++; $display("FAIL div_signed: got hi=%h lo=%h dz=%b expected ffffffff fffffffd 0", r.hi, r.lo, r.dz);
        end
        run_op(1'b0, 3'b011, 32'd100, 32'd7, r);
        checks++; if (r.hi !== 32'd2 || r.lo !== 32'd14) begin failures++; $display("FAIL divu_result: got hi=%0d lo=%0d expected 2 14", r.hi, r.lo); end
        run_op(1'b0, 3'b011, 32'h1234_5678, 32'd0, r);
        checks++; if (r.hi !== 32'h1234_5678 || r.lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divzero_result: got hi=%h lo=%h expected 12345678 ffffffff", r.hi, r.lo); end
        checks++; if (r.dz !== 1'b1) begin failures++; $display("FAIL divzero_flag: got %b expected 1", r.dz); end
        checks++; if (r.stray !== 0 || r.after !== 1'b0) begin failures++; $display("FAIL divzero_pulse: got stray=%0d after=%b expected 0 0", r.stray, r.after); end
        checks++; if (r.lat !== 34) begin failures++; $display("FAIL divzero_latency: got %0d expected 34", r.lat); end
        mhi[0] = 32'h1234_5678; mlo[0] = 32'hFFFF_FFFF;
    endtask

    task automatic test_mt();
        res_t r;
        run_op(1'b0, 3'b110, 32'hA5A5_A5A5, 32'd0, r);
        checks++; if (r.lat !== 1) begin failures++; $display("FAIL mthi_latency: got %0d expected 1", r.lat); end
        checks++; if (r.hi !== 32'hA5A5_A5A5 || r.lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mthi_result: got %h/%h expected a5a5a5a5/ffffffff", r.hi, r.lo); end
        checks++; if (r.after !== 1'b0) begin failures++; $display("FAIL mthi_single_done: got %b expected 0", r.after); end
        run_op(1'b0, 3'b111, 32'h0F0F_0F0F, 32'd0, r);
        checks++; if (r.lo !== 32'h0F0F_0F0F || r.hi !== 32'hA5A5_A5A5 || r.lat !== 1) begin
            failures++; $display("FAIL mtlo_result: got %h/%h lat=%0d expected a5a5a5a5/0f0f0f0f lat=1", r.hi, r.lo, r.lat);
        end
        mhi[0] = 32'hA5A5_A5A5; mlo[0] = 32'h0F0F_0F0F;
    endtask

    task automatic test_ignore_start();
        int cyc;
        int ndone;
        drive(1'b0, 1'b1, 3'b000, 32'd7, 32'd9);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        cyc = 1; ndone = 0;
        while (cyc < 60) begin
            if (cyc == 5) drive(1'b0, 1'b1, 3'b110, 32'hDEAD_BEEF, 32'd1);
            if (cyc == 6) drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
            if (done32) ndone++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_start_done_count: got %0d expected 1", ndone); end
        checks++; if (hi32 !== 32'd0 || lo32 !== 32'd63) begin failures++; $display("FAIL ignore_start_result: got %h/%h expected 00000000/0000003f", hi32, lo32); end
        mhi[0] = 32'd0; mlo[0] = 32'd63;
    endtask

    task automatic test_back_to_back();
        int cyc;
        drive(1'b0, 1'b1, 3'b001, 32'd3, 32'd4);
        @(posedge clk); #1;
        cyc = 1;
        while (!done32 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== 34 || lo32 !== 32'd12 || hi32 !== 32'd0) begin
            failures++; $display("FAIL b2b_first: got lat=%0d %h/%h expected lat=34 00000000/0000000c", cyc, hi32, lo32);
        end
        // start stays high through the done cycle with a new request
        drive(1'b0, 1'b1, 3'b011, 32'd100, 32'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy: got %b expected 1", busy32); end
        cyc = 1;
        while (!done32 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== 34 || lo32 !== 32'd14 || hi32 !== 32'd2) begin
            failures++; $display("FAIL b2b_second: got lat=%0d %h/%h expected lat=34 00000002/0000000e", cyc, hi32, lo32);
        end
        @(posedge clk); #1;
        mhi[0] = 32'd2; mlo[0] = 32'd14;
    endtask

    task automatic test_random(input bit w8, input int n);
        res_t        r;
        int          w;
        int          idx;
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;
        logic        edz;
        w = w8 ? 8 : 32;
        idx = w8 ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(0, 7));
            a = rand_operand(w);
            b = rand_operand(w);
            model(w, op, a, b, mhi[idx], mlo[idx], eh, el, edz);
            run_op(w8, op, a, b, r);
            checks++; if (r.lat !== ((op[2:1] == 2'b11) ? 1 : w + 2)) begin
                failures++; $display("FAIL rand_latency w=%0d op=%0d: got %0d expected %0d", w, op, r.lat, (op[2:1] == 2'b11) ? 1 : w + 2);
            end
            checks++; if (r.hi !== eh || r.lo !== el) begin
                failures++; $display("FAIL rand_result w=%0d op=%0d a=%h b=%h: got %h/%h expected %h/%h", w, op, a, b, r.hi, r.lo, eh, el);
            end
            checks++; if (r.dz !== edz || r.stray !== 0 || r.after !== 1'b0 || r.changed !== 1'b0) begin
                failures++; $display("FAIL rand_pulses w=%0d op=%0d: got dz=%b stray=%0d after=%b changed=%b expected dz=%b 0 0 0", w, op, r.dz, r.stray, r.after, r.changed, edz);
            end
            mhi[idx] = eh; mlo[idx] = el;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int ndone;
        drive(1'b0, 1'b1, 3'b010, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin failures++; $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0 0", busy32, done32); end
        checks++; if (hi32 !== 32'd0 || lo32 !== 32'd0) begin failures++; $display("FAIL midreset_hilo: got %h/%h expected 0/0", hi32, lo32); end
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            if (done32 || dz32 || hi32 !== 32'd0 || lo32 !== 32'd0) ndone++;
            @(posedge clk); #1;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL midreset_no_done: got %0d activity cycles expected 0", ndone); end
        mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    endtask

    task automatic test_width8();
        res_t r;
        run_op(1'b1, 3'b000, 32'hFD, 32'd5, r);
        checks++; if (r.lat !== 10) begin failures++; $display("FAIL w8_mult_latency: got %0d expected 10", r.lat); end
        checks++; if (r.hi !== 32'hFF || r.lo !== 32'hF1) begin failures++; $display("FAIL w8_mult_result: got %h/%h expected ff/f1", r.hi, r.lo); end
        run_op(1'b1, 3'b010, 32'hF9, 32'd2, r);
        checks++; if (r.hi !== 32'hFF || r.lo !== 32'hFD || r.dz !== 1'b0 || r.lat !== 10) begin
            failures++; $display("FAIL w8_div_result: got %h/%h dz=%b lat=%0d expected ff/fd 0 10", r.hi, r.lo, r.dz, r.lat);
        end
        run_op(1'b1, 3'b010, 32'h80, 32'hFF, r);
        checks++; if (r.hi !== 32'h00 || r.lo !== 32'h80 || r.dz !== 1'b0) begin
            failures++; $display("FAIL w8_div_overflow: got %h/%h dz=%b expected 00/80 0", r.hi, r.lo, r.dz);
        end
        mhi[1] = 32'h00; mlo[1] = 32'h80;
        test_random(1'b1, 60);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt();
        test_ignore_start();
        test_back_to_back();
        test_random(1'b0, 40);
        test_reset_mid();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit that owns the architectural HI/LO register pair.
- Successor to the combinational MULT/MADD paths in the datapath ALU. Adds unsigned multiply, signed and unsigned divide, multiply-accumulate, MTHI/MTLO, and a start/busy/done handshake.
- Sits beside the ALU in EX. Control stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; accepted only when busy=0.
- op  input  3  operation, sampled with start: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MTHI, 111 MTLO.
- din1  input  WIDTH  rs operand (multiplicand/dividend/move source).
- din2  input  WIDTH  rt operand (multiplier/divisor).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO updated.
- div_zero  output  1  pulses with done when DIV/DIVU had din2==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - State becomes IDLE; hi, lo, busy, done, div_zero become 0.
  - Reset overrides start.
  - Reset mid-operation abandons the operation; HI/LO do not receive a partial result.
- States: IDLE, CALC, FIX. busy = (state != IDLE), driven from a register.
- Acceptance rule: start=1 and state=IDLE at edge E0.
  - din1, din2 and op are latched at E0. Inputs may change afterwards.
  - start while busy=1 is ignored: no queueing, no error.
- MTHI/MTLO:
  - HI or LO := din1 at E0.
  - State stays IDLE; done=1 during the cycle after E0.
  - Latency 1 cycle.
- MULT/MULTU/MADD/MADDU/DIV/DIVU:
  - E0: go to CALC. Latch operands; signed ops store magnitudes plus the result sign(s); counter := WIDTH.
  - CALC: one radix-2 step per edge, exactly WIDTH edges (E1..E_WIDTH).
    - Multiply is shift-add.
    - Divide is restoring shift-subtract.
  - FIX (edge E_WIDTH+1):
    - Apply sign correction and write HI/LO.
    - Return to IDLE; done=1 and busy=0 in the following cycle.
  - Total latency: WIDTH+2 cycles from the accept edge to the done cycle.
  - A new start may be accepted in the done cycle.
- Arithmetic:
  - MULT/MULTU: {hi,lo} := 2*WIDTH-bit signed/unsigned product.
  - MADD/MADDU: {hi,lo} := {hi,lo} + product, modulo 2^(2*WIDTH). Uses the HI/LO value present at the FIX edge.
  - DIV/DIVU: lo := quotient, hi := remainder.
    - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - DIV of the most-negative value by -1: lo := most-negative, hi := 0. No flag.
  - Divide by zero (din2==0):
    - Still takes the full latency.
    - lo := all ones, hi := din1 (original, unsigned view).
    - div_zero=1 together with done.
- done and div_zero are high for exactly one cycle per completed operation. Both are 0 in every other cycle.
- hi and lo hold their value at all times except the write edge. No intermediate values are visible on hi/lo.

Test Plan:
- MULT, WIDTH=32, din1=0xFFFFFFFD (-3), din2=5 -> done exactly 34 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU din1=0xFFFFFFFF, din2=2 -> hi=0x00000001, lo=0xFFFFFFFE. Repeat as MADDU -> hi=0x00000003, lo=0xFFFFFFFC.
- DIV din1=0xFFFFFFF9 (-7), din2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0. DIVU 100/7 -> lo=14, hi=2.
- DIVU din1=0x12345678, din2=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1 in the done cycle only.
- Handshake:
  - MTHI din1=0xA5A5A5A5 -> hi updated, done the next cycle.
  - A second start pulsed at cycle 5 of a MULT is ignored: exactly one done.
  - A start held in the done cycle is accepted.
- rst=1 at cycle 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows. WIDTH=8 rerun of tests 1 and 3 -> done after 10 cycles with the 8-bit-scaled results.
